// File: rtl/video_timing_generator.sv
// Parametrised VESA-style video timing: sync, blank, pixel coordinates and a lead-time fetch port.
// Optional frame counter output enabled by defining VIDEO_TIMING_FRAME_COUNT_EN.
module video_timing_generator #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit H_SYNC_POL  = 1'b0,
    parameter bit V_SYNC_POL  = 1'b0,
    parameter int COORD_W     = 12,
    parameter int FETCH_LEAD  = 2,
    parameter int FRAME_CNT_W = 16
) (
    input  logic               in_vga_clk,
    input  logic               in_reset_n,
    input  logic               in_enable,
    output logic               out_h_sync,
    output logic               out_v_sync,
    output logic               out_blank_n,
    output logic [COORD_W-1:0] out_pixel_x,
    output logic [COORD_W-1:0] out_pixel_y,
    output logic               out_sol,
    output logic               out_sof,
    output logic               out_fetch_valid,
    output logic [COORD_W-1:0] out_fetch_x,
    output logic [COORD_W-1:0] out_fetch_y
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] out_frame_count
`endif
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;

    // One extra bit so region ends equal to the total still fit when a front porch is zero.
    localparam logic [COORD_W:0] H_SYNC_C  = (COORD_W+1)'(H_SYNC);
    localparam logic [COORD_W:0] V_SYNC_C  = (COORD_W+1)'(V_SYNC);
    localparam logic [COORD_W:0] H_START_C = (COORD_W+1)'(H_START);
    localparam logic [COORD_W:0] V_START_C = (COORD_W+1)'(V_START);
    localparam logic [COORD_W:0] H_END_C   = (COORD_W+1)'(H_START + H_ACTIVE);
    localparam logic [COORD_W:0] V_END_C   = (COORD_W+1)'(V_START + V_ACTIVE);
    localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);

    typedef struct packed {
        logic               hs;
        logic               vs;
        logic               act;
        logic               sol;
        logic               sof;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } stage_t;

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic [COORD_W:0]   h_ext;
    logic [COORD_W:0]   v_ext;
    logic               h_act;
    logic               v_act;
    stage_t             dec;
    stage_t             disp;
    stage_t             stage_q [0:FETCH_LEAD];

    always_ff @(posedge in_vga_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (in_enable) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
            end else begin
                h_cnt <= h_cnt + ONE;
            end
        end
    end

    assign h_ext = {1'b0, h_cnt};
    assign v_ext = {1'b0, v_cnt};
    assign h_act = (h_ext >= H_START_C) && (h_ext < H_END_C);
    assign v_act = (v_ext >= V_START_C) && (v_ext < V_END_C);

    always_comb begin
        dec     = '0;
        dec.hs  = (h_ext < H_SYNC_C);
        dec.vs  = (v_ext < V_SYNC_C);
        dec.act = h_act && v_act;
        if (dec.act) begin
            dec.x = h_cnt - H_START_C[COORD_W-1:0];
            dec.y = v_cnt - V_START_C[COORD_W-1:0];
        end
        dec.sol = dec.act && (dec.x == '0);
        dec.sof = dec.sol && (dec.y == '0);
    end

    // Stage 0 is the fetch register; stage FETCH_LEAD drives the display outputs.
    always_ff @(posedge in_vga_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            for (int i = 0; i <= FETCH_LEAD; i++) begin
                stage_q[i] <= '0;
            end
        end else if (in_enable) begin
            stage_q[0] <= dec;
            for (int i = 1; i <= FETCH_LEAD; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign disp = stage_q[FETCH_LEAD];

    assign out_fetch_valid = stage_q[0].act;
    assign out_fetch_x     = stage_q[0].x;
    assign out_fetch_y     = stage_q[0].y;

    assign out_h_sync  = disp.hs ? H_SYNC_POL : ~H_SYNC_POL;
    assign out_v_sync  = disp.vs ? V_SYNC_POL : ~V_SYNC_POL;
    assign out_blank_n = disp.act;
    assign out_pixel_x = disp.x;
    assign out_pixel_y = disp.y;
    assign out_sol     = disp.sol;
    assign out_sof     = disp.sof;

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    logic disp_sof_nxt;

    // Counter steps on the edge that loads sof into the display stage.
    generate
        if (FETCH_LEAD == 0) begin : g_fc_direct
            assign disp_sof_nxt = dec.sof;
        end else begin : g_fc_piped
            assign disp_sof_nxt = stage_q[FETCH_LEAD-1].sof;
        end
    endgenerate

    always_ff @(posedge in_vga_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            out_frame_count <= '0;
        end else if (in_enable && disp_sof_nxt) begin
            out_frame_count <= out_frame_count + FRAME_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for video_timing_generator: hand-derived timing table, hand sequences and a randomized
// enable/reset run checked against an arithmetic position model.
module tb_video_timing_generator;

    localparam int HA = 8, HF = 2, HSY = 3, HBP = 2;
    localparam int VA = 4, VF = 1, VSY = 2, VBP = 1;
    localparam int HT = HA + HF + HSY + HBP;
    localparam int VT = VA + VF + VSY + VBP;
    localparam int LEAD = 2;
    localparam int CW = 12;
    localparam int FCW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    logic hs, vs, bl, sol, sof, fv;
    logic [CW-1:0] px, py, fx, fy;
    logic hs_p, vs_p, bl_p, sol_p, sof_p, fv_p;
    logic [CW-1:0] px_p, py_p, fx_p, fy_p;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    logic [FCW-1:0] fc, fc_p;
`endif

    int total = 0;
    int bad = 0;
    int e_cnt = 0;

    video_timing_generator #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HBP),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VBP),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .COORD_W(CW),
        .FETCH_LEAD(LEAD), .FRAME_CNT_W(FCW)
    ) dut (
        .in_vga_clk(clk), .in_reset_n(rst_n), .in_enable(en),
        .out_h_sync(hs), .out_v_sync(vs), .out_blank_n(bl),
        .out_pixel_x(px), .out_pixel_y(py), .out_sol(sol), .out_sof(sof),
        .out_fetch_valid(fv), .out_fetch_x(fx), .out_fetch_y(fy)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        , .out_frame_count(fc)
`endif
    );

    video_timing_generator #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HBP),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VBP),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .COORD_W(CW),
        .FETCH_LEAD(LEAD), .FRAME_CNT_W(FCW)
    ) dut_pol (
        .in_vga_clk(clk), .in_reset_n(rst_n), .in_enable(en),
        .out_h_sync(hs_p), .out_v_sync(vs_p), .out_blank_n(bl_p),
        .out_pixel_x(px_p), .out_pixel_y(py_p), .out_sol(sol_p), .out_sof(sof_p),
        .out_fetch_valid(fv_p), .out_fetch_x(fx_p), .out_fetch_y(fy_p)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        , .out_frame_count(fc_p)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int edge_n;
        bit h, v, b, sl, sf, fvl;
        int x, y, fxx, fyy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int e, bit h, bit v, bit b, bit sl, bit sf, bit fvl,
                                int x, int y, int fxx, int fyy);
        vec_t r;
        r.edge_n = e; r.h = h; r.v = v; r.b = b; r.sl = sl; r.sf = sf; r.fvl = fvl;
        r.x = x; r.y = y; r.fxx = fxx; r.fyy = fyy;
        return r;
    endfunction

    function automatic logic [53:0] pack(bit h, bit v, bit b, bit sl, bit sf, bit fvl,
                                         int x, int y, int fxx, int fyy);
        return {h, v, b, sl, sf, fvl, CW'(x), CW'(y), CW'(fxx), CW'(fyy)};
    endfunction

    function automatic logic [53:0] dut_vec();
        return {hs, vs, bl, sol, sof, fv, px, py, fx, fy};
    endfunction

    // Raster position n (enabled edges counted from 0) -> {hs, vs, act, x, y}.
    function automatic logic [26:0] pos(int n);
        int h, v;
        bit a;
        if (n < 0) return '0;
        h = n % HT;
        v = (n / HT) % VT;
        a = (h >= HSY + HBP) && (h < HSY + HBP + HA) && (v >= VSY + VBP) && (v < VSY + VBP + VA);
        return {h < HSY, v < VSY, a, a ? CW'(h - HSY - HBP) : CW'(0), a ? CW'(v - VSY - VBP) : CW'(0)};
    endfunction

    // After e enabled edges: fetch shows position e-1, display shows position e-1-LEAD.
    function automatic logic [53:0] model_vec(int e);
        logic [26:0] d, f;
        bit s_l, s_f;
        d = pos(e - 1 - LEAD);
        f = pos(e - 1);
        s_l = d[24] && (d[23:12] == '0);
        s_f = s_l && (d[11:0] == '0);
        return {~d[26], ~d[25], d[24], s_l, s_f, f[24], d[23:0], f[23:0]};
    endfunction

    function automatic int model_fc(int e);
        int d, first;
        d = e - 1 - LEAD;
        first = (VSY + VBP) * HT + HSY + HBP;
        if (d < first) return 0;
        return ((d - first) / (HT * VT) + 1) % (1 << FCW);
    endfunction

    task automatic cmp(string name, logic [63:0] a, logic [63:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, a, x);
        end
    endtask

    task automatic check_model(string tag);
        logic [53:0] ex;
        ex = model_vec(e_cnt);
        cmp(tag, 64'(dut_vec()), 64'(ex));
        cmp({tag, "_pol"}, 64'({hs_p, vs_p}), 64'({~ex[53], ~ex[52]}));
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        cmp({tag, "_fc"}, 64'(fc), 64'(model_fc(e_cnt)));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (en && rst_n) e_cnt++;
        #1;
    endtask

    // Reset held over two edges; release on a falling edge so the next rising edge is edge 1.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        e_cnt = 0;
        #1;
        check_model("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_model("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl.push_back(mk(0,   1,1,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,   1,1,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(2,   1,1,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(3,   0,0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(5,   0,0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(6,   1,0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(32,  1,0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(33,  0,1,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(50,  0,1,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(51,  1,1,0,0,0,1, 0,0,0,0));
        tbl.push_back(mk(52,  1,1,0,0,0,1, 0,0,1,0));
        tbl.push_back(mk(53,  1,1,1,1,1,1, 0,0,2,0));
        tbl.push_back(mk(54,  1,1,1,0,0,1, 1,0,3,0));
        tbl.push_back(mk(58,  1,1,1,0,0,1, 5,0,7,0));
        tbl.push_back(mk(59,  1,1,1,0,0,0, 6,0,0,0));
        tbl.push_back(mk(60,  1,1,1,0,0,0, 7,0,0,0));
        tbl.push_back(mk(61,  1,1,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(68,  1,1,1,1,0,1, 0,1,2,1));
        tbl.push_back(mk(172, 1,1,0,0,0,1, 0,0,1,0));
        tbl.push_back(mk(173, 1,1,1,1,1,1, 0,0,2,0));

        // Frame timing table from a fresh reset, enable held high.
        en = 1'b1;
        do_reset();
        #1;
        foreach (tbl[k]) begin
            while (e_cnt < tbl[k].edge_n) tick();
            cmp($sformatf("tbl_e%0d", tbl[k].edge_n), 64'(dut_vec()),
                64'(pack(tbl[k].h, tbl[k].v, tbl[k].b, tbl[k].sl, tbl[k].sf, tbl[k].fvl,
                         tbl[k].x, tbl[k].y, tbl[k].fxx, tbl[k].fyy)));
        end

        // Pause: enable low for 5 edges after edge 20; first sof then lands on edge 58.
        do_reset();
        for (int ed = 1; ed <= 58; ed++) begin
            en = (ed >= 21 && ed <= 25) ? 1'b0 : 1'b1;
            tick();
            check_model($sformatf("pause_e%0d", ed));
            if (ed == 57) cmp("pause_sof57", 64'(sof), 64'd0);
            if (ed == 58) cmp("pause_sof58", 64'({sof, bl, px, py}), 64'({1'b1, 1'b1, CW'(0), CW'(0)}));
        end
        en = 1'b1;

        // Mid-frame reset at edge 80: idle immediately, then identical to power-up.
        do_reset();
        repeat (80) tick();
        cmp("pre_rst_hsync", 64'(hs), 64'd0);
        #2;
        rst_n = 1'b0;
        e_cnt = 0;
        #1;
        cmp("midrst_idle", 64'(dut_vec()), 64'(pack(1,1,0,0,0,0, 0,0,0,0)));
        cmp("midrst_pol", 64'({hs_p, vs_p}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (52) tick();
        cmp("midrst_sof52", 64'(sof), 64'd0);
        tick();
        cmp("midrst_sof53", 64'({sof, bl, px, py}), 64'({1'b1, 1'b1, CW'(0), CW'(0)}));

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        // Frame counter steps 1,2,3,0 on successive sof edges.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            while (e_cnt < 53 + 120 * k) tick();
            cmp($sformatf("fc_sof%0d", k), 64'({sof, fc}), 64'({1'b1, FCW'((k + 1) % 4)}));
        end
`endif

        // Randomized enable with occasional async reset, every cycle against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                e_cnt = 0;
                #1;
                check_model("rand_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick();
            check_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_timing_generator.md
Name: video_timing_generator

Overview:
- Parametrised successor to the fixed 640x480 sync generator. Produces h/v sync, blank and pixel coordinates for any VESA-style mode set by parameters.
- Adds programmable sync polarity, start-of-frame/line strobes, a pause enable, and a lead-time fetch port so framebuffer reads can be issued FETCH_LEAD cycles before the pixel is displayed.
- Sits between the pixel clock domain and the framebuffer reader/DAC.

Parameters:
- H_ACTIVE 640: visible pixels per line
- H_FRONT 16: horizontal front porch, pixels
- H_SYNC 96: horizontal sync width, pixels
- H_BACK 48: horizontal back porch, pixels
- V_ACTIVE 480: visible lines per frame
- V_FRONT 10: vertical front porch, lines
- V_SYNC 2: vertical sync width, lines
- V_BACK 33: vertical back porch, lines
- H_SYNC_POL 0: 0 = active-low hsync pulse, 1 = active-high
- V_SYNC_POL 0: 0 = active-low vsync pulse, 1 = active-high
- COORD_W 12: counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- FETCH_LEAD 2: fetch-to-display lead in enabled cycles, range 0..15
- FRAME_CNT_W 16: frame counter width (used only with the optional feature)

Ports:
- in_vga_clk  input  1  pixel clock; all flops on rising edge
- in_reset_n  input  1  asynchronous active-low reset
- in_enable  input  1  1 = advance timing; 0 = freeze all state and outputs
- out_h_sync  output  1  horizontal sync, polarity per H_SYNC_POL
- out_v_sync  output  1  vertical sync, polarity per V_SYNC_POL
- out_blank_n  output  1  1 during active video
- out_pixel_x  output  COORD_W  active x, 0..H_ACTIVE-1; 0 when blanked
- out_pixel_y  output  COORD_W  active y, 0..V_ACTIVE-1; 0 when blanked
- out_sol  output  1  one-cycle pulse with each pixel x=0
- out_sof  output  1  one-cycle pulse with pixel (0,0)
- out_fetch_valid  output  1  out_blank_n will be 1 exactly FETCH_LEAD enabled cycles later
- out_fetch_x  output  COORD_W  x to be displayed FETCH_LEAD enabled cycles later
- out_fetch_y  output  COORD_W  y to be displayed FETCH_LEAD enabled cycles later

Behaviour:
- Derived localparams: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL likewise. H_START = H_SYNC+H_BACK; V_START = V_SYNC+V_BACK.
- Region order per axis, starting at count 0: sync, back porch, active, front porch.
- Lead counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) reset to 0,0.
- On each edge with in_enable=1:
  - h increments; at H_TOTAL-1, h wraps to 0 and v increments.
  - v wraps to 0 when it is V_TOTAL-1 and h also wraps.
- Decode of (h,v):
  - hs = (h < H_SYNC); vs = (v < V_SYNC).
  - act = (H_START <= h < H_START+H_ACTIVE) and (V_START <= v < V_START+V_ACTIVE).
  - x = h-H_START and y = v-V_START when act, else 0.
  - sol = act and x==0; sof = sol and y==0.
- Fetch outputs are registered from the decode of the current (h,v): 1 enabled edge latency.
- Display outputs (sync, blank, pixel, sol, sof) equal the fetch-stage decode delayed by FETCH_LEAD enabled edges through a shift pipeline. FETCH_LEAD=0 means display outputs are the same registers as the fetch stage.
- Sync outputs drive polarity level when hs/vs is true, otherwise the inverse.
- in_enable=0: counters, fetch registers and pipeline all hold. Outputs are static, and pulses stay high if they were high. Timing resumes exactly where it stopped.
- Reset (async assert, sync release):
  - Counters go to 0.
  - All pipeline stages and outputs go to idle: sync at inactive level (~POL), blank_n=0, coordinates 0, sol/sof/fetch_valid 0.
  - Mid-frame reset aborts the frame; after release the sequence is identical to power-up.
- Fetch window wraps across line and frame boundaries with no gap. Fetch of pixel (0,0) occurs during the previous frame's blanking.
- Coordinates are COORD_W unsigned; no saturation needed given the COORD_W constraint.

Optional Feature:
- Macro VIDEO_TIMING_FRAME_COUNT_EN.
- Defined:
  - Adds port out_frame_count, output, FRAME_CNT_W bits, reset 0.
  - Increments by 1 on the same edge out_sof goes high; wraps modulo 2^FRAME_CNT_W.
  - Holds while in_enable=0.
- Undefined: port and counter are absent; all other behaviour is unchanged.

Test Plan:
All scenarios use H 8/2/3/2 (H_TOTAL=15), V 4/1/2/1 (V_TOTAL=8), FETCH_LEAD=2, in_enable=1, and edge 1 = first edge after reset release, unless stated otherwise.
- Frame timing:
  - out_fetch_valid first high after edge 51 with fetch (0,0).
  - out_sof high after edge 53 with pixel (0,0) and blank_n=1 for 8 cycles, x 0..7.
  - Next out_sof after edge 173.
- Sync: out_h_sync low after edges 3..5 then high; out_v_sync low for display lines 0..1 (30 cycles); both high during reset.
- Polarity: H_SYNC_POL=1, V_SYNC_POL=1 → both syncs low in reset/idle; hsync high after edges 3..5.
- Pause: drop in_enable for 5 cycles at edge 20 → all outputs frozen; first out_sof after edge 58.
- Mid-frame reset: assert in_reset_n=0 at edge 80 → outputs idle immediately, without waiting for a clock edge. After release, out_sof again after edge 53.
- Frame counter, with VIDEO_TIMING_FRAME_COUNT_EN and FRAME_CNT_W=2: out_frame_count reads 1,2,3,0 on successive out_sof edges.
